csr_excp_seq: RTL and testbench

//  Exception/ERTN sequencer and access arbiter for the CSR register file (single read + single write port).
//  In idle, passes the WB-stage csrrd/csrwr/csrxchg accesses straight through to the CSR file.
//  On an exception or ERTN, takes over the port and performs the CSR read/modify/write sequence.

---
 rtl/csr_excp_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_csr_excp_seq.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_excp_seq.sv
// ----------------------------------------------------------------------------
// csr_excp_seq
//   Exception / ERTN sequencer and access arbiter for a CSR file that has one
//   read port and one write port.
//   - While idle, instruction csrrd/csrwr/csrxchg accesses pass straight
//     through to the CSR file.
//   - An exception or ERTN takes the port over and runs the CSR
//     read/modify/write sequence. It then pulses a one-cycle fetch redirect.
//
// Configuration macro: CSR_SEQ_BADV_EN
//   defined   : the WR_BADV step exists. It is taken when exc_badv_vld was
//               latched at acceptance.
//   undefined : the step is removed, and exc_badv_vld/exc_badv are ignored.
//
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   exc_req/ecode/esubcode/pc/badv_vld/badv
//                             exception commit from WB and its fields
//   ertn_req                  ertn commit from WB
//   inst_re/we/num/wmask/wvalue
//                             instruction CSR access request
//   inst_rvalue, inst_ready   read data to WB / port granted this cycle
//   csr_re/num/we/wmask/wvalue, csr_rvalue
//                             CSR file port (csr_rvalue is combinational)
//   busy                      sequence in progress
//   redirect_vld, redirect_pc one-cycle fetch redirect and registered target
// ----------------------------------------------------------------------------
module csr_excp_seq #(
    parameter logic [13:0] CSR_CRMD   = 14'h000,
    parameter logic [13:0] CSR_PRMD   = 14'h001,
    parameter logic [13:0] CSR_ESTAT  = 14'h005,
    parameter logic [13:0] CSR_ERA    = 14'h006,
    parameter logic [13:0] CSR_BADV   = 14'h007,
    parameter logic [13:0] CSR_EENTRY = 14'h00c
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_req,
    input  logic [5:0]  exc_ecode,
    input  logic [8:0]  exc_esubcode,
    input  logic [31:0] exc_pc,
    input  logic        exc_badv_vld,
    input  logic [31:0] exc_badv,
    input  logic        ertn_req,
    input  logic        inst_re,
    input  logic        inst_we,
    input  logic [13:0] inst_num,
    input  logic [31:0] inst_wmask,
    input  logic [31:0] inst_wvalue,
    output logic [31:0] inst_rvalue,
    output logic        inst_ready,
    output logic        csr_re,
    output logic [13:0] csr_num,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        busy,
    output logic        redirect_vld,
    output logic [31:0] redirect_pc
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_E_RD_CRMD,
        S_E_WR_PRMD,
        S_E_WR_CRMD,
        S_E_WR_ESTAT,
        S_E_WR_ERA,
`ifdef CSR_SEQ_BADV_EN
        S_E_WR_BADV,
`endif
        S_E_RD_EENTRY,
        S_R_RD_PRMD,
        S_R_WR_CRMD,
        S_R_RD_ERA,
        S_REDIR
    } state_e;

    state_e      state_q, state_d;
    // Only the PLV/IE bits of the saved CRMD/PRMD value are ever written back.
    logic [2:0]  tmp_q, tmp_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] pc_q, pc_d;
`ifdef CSR_SEQ_BADV_EN
    logic        badv_vld_q, badv_vld_d;
    logic [31:0] badv_q, badv_d;
`else
    logic        unused_badv;
    assign unused_badv = ^{exc_badv_vld, exc_badv, CSR_BADV};
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            tmp_q         <= '0;
            redirect_pc_q <= '0;
            ecode_q       <= '0;
            esub_q        <= '0;
            pc_q          <= '0;
`ifdef CSR_SEQ_BADV_EN
            badv_vld_q    <= 1'b0;
            badv_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tmp_q         <= tmp_d;
            redirect_pc_q <= redirect_pc_d;
            ecode_q       <= ecode_d;
            esub_q        <= esub_d;
            pc_q          <= pc_d;
`ifdef CSR_SEQ_BADV_EN
            badv_vld_q    <= badv_vld_d;
            badv_q        <= badv_d;
`endif
        end
    end

    // Next state and register updates
    always_comb begin
        state_d       = state_q;
        tmp_d         = tmp_q;
        redirect_pc_d = redirect_pc_q;
        ecode_d       = ecode_q;
        esub_d        = esub_q;
        pc_d          = pc_q;
`ifdef CSR_SEQ_BADV_EN
        badv_vld_d    = badv_vld_q;
        badv_d        = badv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (exc_req) begin
                    state_d    = S_E_RD_CRMD;
                    ecode_d    = exc_ecode;
                    esub_d     = exc_esubcode;
                    pc_d       = exc_pc;
`ifdef CSR_SEQ_BADV_EN
                    badv_vld_d = exc_badv_vld;
                    badv_d     = exc_badv;
`endif
                end else if (ertn_req) begin
                    state_d = S_R_RD_PRMD;
                end
            end
            S_E_RD_CRMD: begin
                tmp_d   = csr_rvalue[2:0];
                state_d = S_E_WR_PRMD;
            end
            S_E_WR_PRMD:  state_d = S_E_WR_CRMD;
            S_E_WR_CRMD:  state_d = S_E_WR_ESTAT;
            S_E_WR_ESTAT: state_d = S_E_WR_ERA;
`ifdef CSR_SEQ_BADV_EN
            S_E_WR_ERA:   state_d = badv_vld_q ? S_E_WR_BADV : S_E_RD_EENTRY;
            S_E_WR_BADV:  state_d = S_E_RD_EENTRY;
`else
            S_E_WR_ERA:   state_d = S_E_RD_EENTRY;
`endif
            S_E_RD_EENTRY: begin
                redirect_pc_d = csr_rvalue;
                state_d       = S_REDIR;
            end
            S_R_RD_PRMD: begin
                tmp_d   = csr_rvalue[2:0];
                state_d = S_R_WR_CRMD;
            end
            S_R_WR_CRMD:  state_d = S_R_RD_ERA;
            S_R_RD_ERA: begin
                redirect_pc_d = csr_rvalue;
                state_d       = S_REDIR;
            end
            // A request seen during REDIR is not accepted here. The next
            // IDLE cycle accepts it.
            S_REDIR:      state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Port ownership and outputs
    always_comb begin
        inst_ready   = 1'b0;
        inst_rvalue  = '0;
        csr_re       = 1'b0;
        csr_we       = 1'b0;
        csr_num      = '0;
        csr_wmask    = '0;
        csr_wvalue   = '0;
        busy         = (state_q != S_IDLE);
        redirect_vld = (state_q == S_REDIR);
        redirect_pc  = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                // Pass-through is also gated by reset, so the port stays
                // quiet while resetn is held low.
                if (resetn && !exc_req && !ertn_req) begin
                    inst_ready  = 1'b1;
                    inst_rvalue = csr_rvalue;
                    csr_re      = inst_re;
                    csr_we      = inst_we;
                    csr_num     = inst_num;
                    csr_wmask   = inst_wmask;
                    csr_wvalue  = inst_wvalue;
                end
            end
            S_E_RD_CRMD: begin
                csr_re  = 1'b1;
                csr_num = CSR_CRMD;
            end
            S_E_WR_PRMD: begin
                csr_we     = 1'b1;
                csr_num    = CSR_PRMD;
                csr_wmask  = 32'h0000_0007;
                csr_wvalue = {29'b0, tmp_q};
            end
            S_E_WR_CRMD: begin
                csr_we     = 1'b1;
                csr_num    = CSR_CRMD;
                csr_wmask  = 32'h0000_0007;
                csr_wvalue = '0;
            end
            S_E_WR_ESTAT: begin
                csr_we     = 1'b1;
                csr_num    = CSR_ESTAT;
                csr_wmask  = 32'h7FFF_0000;
                csr_wvalue = {1'b0, esub_q, ecode_q, 16'h0000};
            end
            S_E_WR_ERA: begin
                csr_we     = 1'b1;
                csr_num    = CSR_ERA;
                csr_wmask  = '1;
                csr_wvalue = pc_q;
            end
`ifdef CSR_SEQ_BADV_EN
            S_E_WR_BADV: begin
                csr_we     = 1'b1;
                csr_num    = CSR_BADV;
                csr_wmask  = '1;
                csr_wvalue = badv_q;
            end
`endif
            S_E_RD_EENTRY: begin
                csr_re  = 1'b1;
                csr_num = CSR_EENTRY;
            end
            S_R_RD_PRMD: begin
                csr_re  = 1'b1;
                csr_num = CSR_PRMD;
            end
            S_R_WR_CRMD: begin
                csr_we     = 1'b1;
                csr_num    = CSR_CRMD;
                csr_wmask  = 32'h0000_0007;
                csr_wvalue = {29'b0, tmp_q};
            end
            S_R_RD_ERA: begin
                csr_re  = 1'b1;
                csr_num = CSR_ERA;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_excp_seq.sv
// ----------------------------------------------------------------------------
// tb_csr_excp_seq
//   Self-checking bench for csr_excp_seq. A small CSR file (16 entries,
//   indexed by csr_num[3:0]) sits behind the DUT port.
//   Expected CSR contents, redirect timing and targets come from the
//   architectural rules for exceptions and ERTN.
// ----------------------------------------------------------------------------
module tb_csr_excp_seq;

`ifdef CSR_SEQ_BADV_EN
    localparam bit BADV_EN = 1'b1;
`else
    localparam bit BADV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_req;
    logic [5:0]  exc_ecode;
    logic [8:0]  exc_esubcode;
    logic [31:0] exc_pc;
    logic        exc_badv_vld;
    logic [31:0] exc_badv;
    logic        ertn_req;
    logic        inst_re;
    logic        inst_we;
    logic [13:0] inst_num;
    logic [31:0] inst_wmask;
    logic [31:0] inst_wvalue;
    logic [31:0] inst_rvalue;
    logic        inst_ready;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        busy;
    logic        redirect_vld;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_excp_seq dut (
        .clk          (clk),
        .resetn       (resetn),
        .exc_req      (exc_req),
        .exc_ecode    (exc_ecode),
        .exc_esubcode (exc_esubcode),
        .exc_pc       (exc_pc),
        .exc_badv_vld (exc_badv_vld),
        .exc_badv     (exc_badv),
        .ertn_req     (ertn_req),
        .inst_re      (inst_re),
        .inst_we      (inst_we),
        .inst_num     (inst_num),
        .inst_wmask   (inst_wmask),
        .inst_wvalue  (inst_wvalue),
        .inst_rvalue  (inst_rvalue),
        .inst_ready   (inst_ready),
        .csr_re       (csr_re),
        .csr_num      (csr_num),
        .csr_rvalue   (csr_rvalue),
        .csr_we       (csr_we),
        .csr_wmask    (csr_wmask),
        .csr_wvalue   (csr_wvalue),
        .busy         (busy),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc)
    );

    // CSR file behind the port, with a bench-side preload path
    logic [31:0] mem [0:15];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign csr_rvalue = mem[csr_num[3:0]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (csr_we)
            mem[csr_num[3:0]] <= (mem[csr_num[3:0]] & ~csr_wmask) | (csr_wvalue & csr_wmask);
    end

    task automatic poke(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Observes cycles 1..maxc after an acceptance cycle. Only collects data;
    // the callers do the comparisons.
    task automatic watch_seq(input int maxc, input bit keep_ertn,
                             output int first, output int npulse,
                             output logic [31:0] pc, output int busy_cnt,
                             output int viol);
        first = -1; npulse = 0; pc = '0; busy_cnt = 0; viol = 0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (k == 1) begin
                exc_req = 1'b0;
                inst_we = 1'b0;
                if (!keep_ertn) ertn_req = 1'b0;
            end
            #1;
            if (redirect_vld) begin
                npulse++;
                if (first < 0) begin
                    first = k;
                    pc    = redirect_pc;
                end
            end
            if (busy) busy_cnt++;
            if ((csr_re && csr_we) || (busy && (inst_ready || inst_rvalue != 32'h0)))
                viol++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        exc_req = 1'b0; ertn_req = 1'b0;
        exc_ecode = '0; exc_esubcode = '0; exc_pc = '0;
        exc_badv_vld = 1'b0; exc_badv = '0;
        inst_re = 1'b1; inst_we = 1'b1; inst_num = 14'h003;
        inst_wmask = '1; inst_wvalue = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, redirect_vld, csr_we, csr_re, inst_ready} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, redirect_vld, csr_we, csr_re, inst_ready});
        checks++;
        if (redirect_pc !== 32'h0)
            $display("FAIL reset_redirect_pc: got %h expected 00000000", redirect_pc);
        if ({busy, redirect_vld, csr_we, csr_re, inst_ready} !== 5'b0 || redirect_pc !== 32'h0)
            errors++;
        @(negedge clk);
        inst_re = 1'b0; inst_we = 1'b0; inst_num = '0;
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) poke(4'(i), $urandom);
    endtask

    task automatic test_passthrough();
        logic [31:0] r;
        logic [31:0] expv;
        @(negedge clk);
        inst_we = 1'b1; inst_re = 1'b0; inst_num = 14'h00C;
        inst_wmask = 32'hFFFF_FFFF; inst_wvalue = 32'h1C00_0000;
        #1;
        checks++;
        if ({csr_we, csr_num, inst_ready, csr_wmask, csr_wvalue} !== {1'b1, 14'h00C, 1'b1, 32'hFFFF_FFFF, 32'h1C00_0000}) begin
            errors++;
            $display("FAIL pass_directed: got we=%b num=%h rdy=%b mask=%h wv=%h expected 1 00c 1 ffffffff 1c000000",
                     csr_we, csr_num, inst_ready, csr_wmask, csr_wvalue);
        end
        @(negedge clk);
        inst_we = 1'b0;
        checks++;
        if (mem[12] !== 32'h1C00_0000) begin
            errors++;
            $display("FAIL pass_write: got %h expected 1c000000", mem[12]);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            r = $urandom;
            inst_re = r[0]; inst_we = r[1];
            inst_num = 14'($urandom);
            inst_wmask = $urandom; inst_wvalue = $urandom;
            #1;
            expv = mem[inst_num[3:0]];
            checks++;
            if ({csr_re, csr_we, csr_num, csr_wmask, csr_wvalue, inst_ready, busy, redirect_vld} !==
                {inst_re, inst_we, inst_num, inst_wmask, inst_wvalue, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL pass_rand_port: got re=%b we=%b num=%h rdy=%b busy=%b expected re=%b we=%b num=%h rdy=1 busy=0",
                         csr_re, csr_we, csr_num, inst_ready, busy, inst_re, inst_we, inst_num);
            end
            checks++;
            if (inst_rvalue !== expv) begin
                errors++;
                $display("FAIL pass_rand_rvalue: got %h expected %h", inst_rvalue, expv);
            end
        end
        @(negedge clk);
        inst_re = 1'b0; inst_we = 1'b0;
    endtask

    task automatic test_exception(input logic [31:0] crmd_old, input logic [5:0] ecode,
                                  input logic [8:0] sub, input logic [31:0] pc,
                                  input logic bv, input logic [31:0] bad,
                                  input logic [31:0] eentry);
        logic [31:0] exp [16];
        logic [31:0] rpc;
        int lat, first, npulse, bcnt, viol;
        poke(4'h0, crmd_old);
        poke(4'h1, $urandom);
        poke(4'h5, $urandom);
        poke(4'h6, $urandom);
        poke(4'h7, $urandom);
        poke(4'hC, eentry);
        for (int i = 0; i < 16; i++) exp[i] = mem[i];
        exp[1] = (exp[1] & ~32'h7) | (crmd_old & 32'h7);
        exp[0] = exp[0] & ~32'h7;
        exp[5] = (exp[5] & ~32'h7FFF_0000) | {1'b0, sub, ecode, 16'h0};
        exp[6] = pc;
        if (BADV_EN && bv) exp[7] = bad;
        lat = (BADV_EN && bv) ? 8 : 7;
        exc_req = 1'b1; exc_ecode = ecode; exc_esubcode = sub; exc_pc = pc;
        exc_badv_vld = bv; exc_badv = bad;
        inst_re = 1'b1; inst_num = 14'h005;
        #1;
        checks++;
        if (inst_ready !== 1'b0 || csr_we !== 1'b0) begin
            errors++;
            $display("FAIL exc_accept: got rdy=%b we=%b expected 0 0", inst_ready, csr_we);
        end
        watch_seq(lat + 3, 1'b0, first, npulse, rpc, bcnt, viol);
        inst_re = 1'b0;
        checks++;
        if (first !== lat || npulse !== 1) begin
            errors++;
            $display("FAIL exc_redirect_timing: got cycle %0d pulses %0d expected cycle %0d pulses 1", first, npulse, lat);
        end
        checks++;
        if (rpc !== eentry) begin
            errors++;
            $display("FAIL exc_redirect_pc: got %h expected %h", rpc, eentry);
        end
        checks++;
        if (bcnt !== lat || viol !== 0) begin
            errors++;
            $display("FAIL exc_busy: got busy cycles %0d violations %0d expected %0d 0", bcnt, viol, lat);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== exp[i]) begin
                errors++;
                $display("FAIL exc_csr[%0d]: got %h expected %h", i, mem[i], exp[i]);
            end
        end
    endtask

    task automatic test_ertn(input logic [31:0] prmd, input logic [31:0] era);
        logic [31:0] crmd_exp;
        logic [31:0] rpc;
        int first, npulse, bcnt, viol;
        poke(4'h0, $urandom);
        poke(4'h1, prmd);
        poke(4'h6, era);
        crmd_exp = (mem[0] & ~32'h7) | (prmd & 32'h7);
        ertn_req = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b0 || csr_we !== 1'b0) begin
            errors++;
            $display("FAIL ertn_accept: got rdy=%b we=%b expected 0 0", inst_ready, csr_we);
        end
        watch_seq(7, 1'b0, first, npulse, rpc, bcnt, viol);
        checks++;
        if (first !== 4 || npulse !== 1 || rpc !== era) begin
            errors++;
            $display("FAIL ertn_redirect: got cycle %0d pulses %0d pc %h expected cycle 4 pulses 1 pc %h", first, npulse, rpc, era);
        end
        checks++;
        if (bcnt !== 4 || viol !== 0) begin
            errors++;
            $display("FAIL ertn_busy: got busy cycles %0d violations %0d expected 4 0", bcnt, viol);
        end
        checks++;
        if (mem[0] !== crmd_exp) begin
            errors++;
            $display("FAIL ertn_crmd: got %h expected %h", mem[0], crmd_exp);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] keep15;
        logic [31:0] rpc;
        int first, npulse, bcnt, viol;
        poke(4'h0, 32'h0000_0003);
        poke(4'hC, 32'h1C00_4000);
        keep15 = mem[15];
        exc_req = 1'b1; ertn_req = 1'b1;
        exc_ecode = 6'h01; exc_esubcode = '0; exc_pc = 32'h1C00_0200;
        exc_badv_vld = 1'b0; exc_badv = '0;
        inst_we = 1'b1; inst_num = 14'h00F; inst_wmask = '1; inst_wvalue = ~keep15;
        #1;
        checks++;
        if (inst_ready !== 1'b0 || csr_we !== 1'b0) begin
            errors++;
            $display("FAIL sim_accept: got rdy=%b we=%b expected 0 0", inst_ready, csr_we);
        end
        // ertn_req stays high through busy and through REDIR
        watch_seq(8, 1'b1, first, npulse, rpc, bcnt, viol);
        checks++;
        if (first !== 7 || npulse !== 1 || rpc !== 32'h1C00_4000 || bcnt !== 7) begin
            errors++;
            $display("FAIL sim_exc_seq: got cycle %0d pulses %0d pc %h busy %0d expected 7 1 1c004000 7", first, npulse, rpc, bcnt);
        end
        checks++;
        if (busy !== 1'b0 || inst_ready !== 1'b0) begin
            errors++;
            $display("FAIL sim_ertn_accept: got busy=%b rdy=%b expected 0 0", busy, inst_ready);
        end
        watch_seq(7, 1'b0, first, npulse, rpc, bcnt, viol);
        checks++;
        if (first !== 4 || npulse !== 1 || rpc !== 32'h1C00_0200) begin
            errors++;
            $display("FAIL sim_ertn_seq: got cycle %0d pulses %0d pc %h expected 4 1 1c000200", first, npulse, rpc);
        end
        checks++;
        if (mem[15] !== keep15 || mem[0][2:0] !== 3'h3) begin
            errors++;
            $display("FAIL sim_csr: got csr15=%h crmd=%h expected csr15=%h crmd[2:0]=3", mem[15], mem[0], keep15);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rpc;
        int first, npulse, bcnt, viol;
        poke(4'h0, 32'h0000_0007);
        exc_req = 1'b1; exc_ecode = 6'h0B; exc_esubcode = 9'h001;
        exc_pc = 32'h1C00_0300; exc_badv_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exc_req = 1'b0;
        end
        #1;
        checks++;
        if (busy !== 1'b1 || csr_we !== 1'b1 || csr_num !== 14'h005) begin
            errors++;
            $display("FAIL mid_estat_state: got busy=%b we=%b num=%h expected 1 1 005", busy, csr_we, csr_num);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({busy, redirect_vld, csr_we, csr_re, inst_ready} !== 5'b0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ctrl=%b pc=%h expected 00000 00000000",
                     {busy, redirect_vld, csr_we, csr_re, inst_ready}, redirect_pc);
        end
        @(negedge clk);
        resetn = 1'b1;
        watch_seq(10, 1'b0, first, npulse, rpc, bcnt, viol);
        checks++;
        if (npulse !== 0 || bcnt !== 0) begin
            errors++;
            $display("FAIL mid_no_redirect: got pulses %0d busy %0d expected 0 0", npulse, bcnt);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_exception(32'h0000_0007, 6'h0B, 9'h000, 32'h1C00_0100, 1'b0, 32'h0, 32'h1C00_8000);
        test_exception(32'h0000_0002, 6'h09, 9'h000, 32'h1C00_0180, 1'b1, 32'hDEAD_0003, 32'h1C00_8000);
        for (int i = 0; i < 6; i++)
            test_exception($urandom, 6'($urandom), 9'($urandom), $urandom,
                           1'($urandom), $urandom, $urandom);
        test_ertn(32'h0000_0005, 32'h1C00_0104);
        for (int i = 0; i < 4; i++) test_ertn($urandom, $urandom);
        test_simultaneous();
        test_reset_mid();
        test_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
